// File: rtl/ber_stream_monitor_if.sv
// Bundles the config, tx/rx stream and result signals of ber_stream_monitor.
// Optional FIRST_ERR_CAPTURE_EN adds the first-mismatch capture outputs.
interface ber_stream_monitor_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SKIP_W = 8
);
    logic              start;
    logic [SKIP_W-1:0] skip_cnt;
    logic [CNT_W-1:0]  window;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pair_cnt;
    logic [CNT_W-1:0]  word_err_cnt;
    logic [CNT_W-1:0]  bit_err_cnt;
    logic              overflow;
    logic              underflow;
`ifdef FIRST_ERR_CAPTURE_EN
    logic              first_err_valid;
    logic [DATA_W-1:0] first_err_exp;
    logic [DATA_W-1:0] first_err_got;
    logic [CNT_W-1:0]  first_err_idx;
`endif

    modport master (
        output start, skip_cnt, window, tx_valid, tx_data, rx_valid, rx_data,
        input  busy, done, pair_cnt, word_err_cnt, bit_err_cnt, overflow, underflow
`ifdef FIRST_ERR_CAPTURE_EN
        , input first_err_valid, first_err_exp, first_err_got, first_err_idx
`endif
    );

    modport slave (
        input  start, skip_cnt, window, tx_valid, tx_data, rx_valid, rx_data,
        output busy, done, pair_cnt, word_err_cnt, bit_err_cnt, overflow, underflow
`ifdef FIRST_ERR_CAPTURE_EN
        , output first_err_valid, first_err_exp, first_err_got, first_err_idx
`endif
    );
endinterface

// File: rtl/ber_stream_monitor.sv
// Link checker: pairs tx words with rx words through a reference FIFO, skips a warm-up
// count, then scores word/bit errors over a window. FIRST_ERR_CAPTURE_EN adds first-error capture.
module ber_stream_monitor #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SKIP_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ber_stream_monitor_if.slave   bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned PC_W  = $clog2(DATA_W + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_MEASURE, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [SKIP_W-1:0] skip_rem_q, skip_rem_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]  word_err_q, word_err_d;
    logic [CNT_W-1:0]  bit_err_q, bit_err_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              active, push_req, pop_req, push_ok, pop_ok;
    logic              fifo_empty, fifo_full, mism;
    logic [DATA_W-1:0] head, diff;

`ifdef FIRST_ERR_CAPTURE_EN
    logic              fe_valid_q, fe_valid_d;
    logic [DATA_W-1:0] fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;
    logic [CNT_W-1:0]  fe_idx_q, fe_idx_d;
`endif

    function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DATA_W); i++) n = n + PC_W'(v[i]);
        return n;
    endfunction

    // Saturating add of a small increment onto a counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
        return CNT_W'(s);
    endfunction

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        skip_rem_d  = skip_rem_q;
        win_d       = win_q;
        pair_cnt_d  = pair_cnt_q;
        word_err_d  = word_err_q;
        bit_err_d   = bit_err_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
`ifdef FIRST_ERR_CAPTURE_EN
        fe_valid_d  = fe_valid_q;
        fe_exp_d    = fe_exp_q;
        fe_got_d    = fe_got_q;
        fe_idx_d    = fe_idx_q;
`endif

        active     = (state_q == S_WARMUP) || (state_q == S_MEASURE);
        push_req   = active && bus.tx_valid;
        pop_req    = active && bus.rx_valid;
        fifo_empty = (occ_q == '0);
        fifo_full  = (occ_q == OCC_FULL);
        // Pop is evaluated first, so a full FIFO still accepts a push alongside a pop.
        pop_ok     = pop_req && !fifo_empty;
        push_ok    = push_req && (!fifo_full || pop_ok);
        head       = mem_q[rd_ptr_q];
        diff       = bus.rx_data ^ head;
        mism       = |diff;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    occ_d       = '0;
                    pair_cnt_d  = '0;
                    word_err_d  = '0;
                    bit_err_d   = '0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
                    fe_valid_d  = 1'b0;
                    fe_exp_d    = '0;
                    fe_got_d    = '0;
                    fe_idx_d    = '0;
`endif
                    skip_rem_d  = bus.skip_cnt;
                    win_d       = (bus.window == '0) ? CNT_W'(1) : bus.window;
                    state_d     = (bus.skip_cnt == '0) ? S_MEASURE : S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (pop_ok) begin
                    skip_rem_d = skip_rem_q - SKIP_W'(1);
                    if (skip_rem_q == SKIP_W'(1)) state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (pop_ok) begin
                    pair_cnt_d = sat_add(pair_cnt_q, PC_W'(1));
                    if (mism) begin
                        word_err_d = sat_add(word_err_q, PC_W'(1));
                        bit_err_d  = sat_add(bit_err_q, popcount(diff));
`ifdef FIRST_ERR_CAPTURE_EN
                        if (!fe_valid_q) begin
                            fe_valid_d = 1'b1;
                            fe_exp_d   = head;
                            fe_got_d   = bus.rx_data;
                            fe_idx_d   = pair_cnt_q;
                        end
`endif
                    end
                    if (pair_cnt_q == win_q - CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // FIFO bookkeeping; push_ok/pop_ok are only ever set while active.
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (active) occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
        if (pop_req && fifo_empty)           underflow_d = 1'b1;
        if (push_req && fifo_full && !pop_ok) overflow_d = 1'b1;

        busy_d = (state_d == S_WARMUP) || (state_d == S_MEASURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            skip_rem_q  <= '0;
            win_q       <= '0;
            pair_cnt_q  <= '0;
            word_err_q  <= '0;
            bit_err_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FIRST_ERR_CAPTURE_EN
            fe_valid_q  <= 1'b0;
            fe_exp_q    <= '0;
            fe_got_q    <= '0;
            fe_idx_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            skip_rem_q  <= skip_rem_d;
            win_q       <= win_d;
            pair_cnt_q  <= pair_cnt_d;
            word_err_q  <= word_err_d;
            bit_err_q   <= bit_err_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef FIRST_ERR_CAPTURE_EN
            fe_valid_q  <= fe_valid_d;
            fe_exp_q    <= fe_exp_d;
            fe_got_q    <= fe_got_d;
            fe_idx_q    <= fe_idx_d;
`endif
        end
    end

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.tx_data;
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pair_cnt     = pair_cnt_q;
    assign bus.word_err_cnt = word_err_q;
    assign bus.bit_err_cnt  = bit_err_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
`ifdef FIRST_ERR_CAPTURE_EN
    assign bus.first_err_valid = fe_valid_q;
    assign bus.first_err_exp   = fe_exp_q;
    assign bus.first_err_got   = fe_got_q;
    assign bus.first_err_idx   = fe_idx_q;
`endif
endmodule

// File: tb/tb_ber_stream_monitor.sv
// Bench for ber_stream_monitor: a default instance plus a CNT_W=4 instance sharing stimulus.
// Expected counts come from the injected error masks over the scored index range.
module tb_ber_stream_monitor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ber_stream_monitor_if #(.DATA_W(8), .CNT_W(16), .SKIP_W(8)) bus ();
    ber_stream_monitor_if #(.DATA_W(8), .CNT_W(4),  .SKIP_W(8)) bus_s ();

    ber_stream_monitor #(.DATA_W(8), .DEPTH(16), .CNT_W(16), .SKIP_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    ber_stream_monitor #(.DATA_W(8), .DEPTH(16), .CNT_W(4), .SKIP_W(8)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s));

    assign bus_s.start    = bus.start;
    assign bus_s.skip_cnt = bus.skip_cnt;
    assign bus_s.window   = bus.window[3:0];
    assign bus_s.tx_valid = bus.tx_valid;
    assign bus_s.tx_data  = bus.tx_data;
    assign bus_s.rx_valid = bus.rx_valid;
    assign bus_s.rx_data  = bus.rx_data;

    int total = 0;
    int bad = 0;
    logic [7:0] mask_a [512];
    logic [7:0] words  [32];
    bit small_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.tx_valid = 1'b0; bus.rx_valid = 1'b0;
        bus.tx_data = '0; bus.rx_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic do_start(input int skip, input int win);
        bus.skip_cnt = 8'(skip);
        bus.window   = 16'(win);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic pair(input bit tv, input logic [7:0] td, input bit rv, input logic [7:0] rd);
        bus.tx_valid = tv; bus.tx_data = td; bus.rx_valid = rv; bus.rx_data = rd;
        step();
        bus.tx_valid = 1'b0; bus.rx_valid = 1'b0;
    endtask

    function automatic int popc(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // Streams n words through a fixed-latency loopback with mask_a errors, then checks results.
    task automatic drive_run(input string tag, input int skip, input int win, input int n,
                             input int lat);
        logic [7:0] txq[$];
        int         txc[$];
        int cyc = 0, sent_tx = 0, sent_rx = 0, rx_at_done = -1;
        int eff_win, exp_we = 0, exp_be = 0;
        bit got_done = 0;
        logic [7:0] w;
        eff_win = (win == 0) ? 1 : win;
        for (int i = skip; i < skip + eff_win; i++) begin
            if (mask_a[i] != 0) exp_we++;
            exp_be += popc(mask_a[i]);
        end
        small_done = 0;
        do_start(skip, win);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (!got_done && cyc < 3000) begin
            bus.tx_valid = 1'b0; bus.rx_valid = 1'b0;
            if (sent_tx < n && $urandom_range(0, 9) < 7) begin
                w = 8'($urandom);
                bus.tx_valid = 1'b1; bus.tx_data = w;
                txq.push_back(w); txc.push_back(cyc);
                sent_tx++;
            end
            if (txq.size() > 0 && txc[0] + lat <= cyc) begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = txq[0] ^ mask_a[sent_rx];
                void'(txq.pop_front()); void'(txc.pop_front());
                sent_rx++;
            end
            step();
            cyc++;
            if (bus_s.done) small_done = 1;
            if (bus.done) begin got_done = 1; rx_at_done = sent_rx; end
        end
        idle_inputs();
        check({tag, "_done"}, 32'(got_done), 32'd1);
        check({tag, "_rx_at_done"}, 32'(rx_at_done), 32'(skip + eff_win));
        check({tag, "_pair"}, 32'(bus.pair_cnt), 32'(eff_win));
        check({tag, "_word_err"}, 32'(bus.word_err_cnt), 32'(exp_we));
        check({tag, "_bit_err"}, 32'(bus.bit_err_cnt), 32'(exp_be));
        check({tag, "_flags"}, {30'd0, bus.overflow, bus.underflow}, 32'd0);
        step();
        check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        int skip, win, lat;
        idle_inputs();
        bus.skip_cnt = '0; bus.window = '0;

        // Reset state
        do_reset();
        step();
        check("rst_status", {30'd0, bus.busy, bus.done}, 32'd0);
        check("rst_cnts", 32'(bus.pair_cnt) | 32'(bus.word_err_cnt) | 32'(bus.bit_err_cnt), 32'd0);
        check("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        check("rst_small", {27'd0, bus_s.busy, bus_s.pair_cnt}, 32'd0);

        // Lossless loop, latency 5, skip 3, window 100
        for (int i = 0; i < 512; i++) mask_a[i] = '0;
        drive_run("lossless", 3, 100, 110, 5);

        // Two 0x81 errors at scored pairs 10 and 20
        for (int i = 0; i < 512; i++) mask_a[i] = '0;
        mask_a[10] = 8'h81; mask_a[20] = 8'h81;
        drive_run("err81", 0, 50, 50, 3);
`ifdef FIRST_ERR_CAPTURE_EN
        check("fe_valid", 32'(bus.first_err_valid), 32'd1);
        check("fe_idx", 32'(bus.first_err_idx), 32'd10);
        check("fe_xor", 32'(bus.first_err_exp ^ bus.first_err_got), 32'h81);
`endif

        // Randomized runs
        for (int r = 0; r < 3; r++) begin
            skip = $urandom_range(0, 10);
            win  = $urandom_range(20, 60);
            lat  = $urandom_range(1, 12);
            for (int i = 0; i < 512; i++)
                mask_a[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            drive_run($sformatf("rand%0d", r), skip, win, skip + win + 5, lat);
        end

        // window==0 scores exactly one pair
        for (int i = 0; i < 512; i++) mask_a[i] = '0;
        drive_run("win0", 0, 0, 3, 1);

        // Overflow: 17 pushes into a 16-deep FIFO, then drain 16 in order
        do_start(0, 16);
        for (int i = 0; i < 17; i++) begin
            words[i] = 8'($urandom);
            pair(1'b1, words[i], 1'b0, 8'h00);
        end
        check("ovf_flag", {30'd0, bus.overflow, bus.underflow}, 32'd2);
        for (int i = 0; i < 16; i++) pair(1'b0, 8'h00, 1'b1, words[i]);
        check("ovf_done", 32'(bus.done), 32'd1);
        check("ovf_pair", 32'(bus.pair_cnt), 32'd16);
        check("ovf_err", 32'(bus.word_err_cnt), 32'd0);
        step();

        // Underflow, then push+pop on an empty FIFO
        do_start(0, 5);
        pair(1'b0, 8'h00, 1'b1, 8'h00);
        check("unf_flag", {30'd0, bus.overflow, bus.underflow}, 32'd1);
        check("unf_pair0", 32'(bus.pair_cnt), 32'd0);
        pair(1'b1, 8'h5A, 1'b1, 8'h33);
        check("unf_pp_pair", 32'(bus.pair_cnt), 32'd0);
        check("unf_pp_err", 32'(bus.word_err_cnt), 32'd0);
        pair(1'b0, 8'h00, 1'b1, 8'h5A);
        check("unf_kept_word", {16'(bus.word_err_cnt), 16'(bus.pair_cnt)}, 32'd1);
        pair(1'b1, 8'h11, 1'b0, 8'h00);
        pair(1'b0, 8'h00, 1'b1, 8'h11);
        check("unf_pair2", 32'(bus.pair_cnt), 32'd2);

        // start ignored while busy; reset mid-MEASURE clears everything
        do_reset();
        do_start(0, 20);
        words[0] = 8'($urandom);
        pair(1'b1, words[0], 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            words[i] = 8'($urandom);
            pair(1'b1, words[i], 1'b1, words[i-1]);
        end
        do_start(9, 3);
        check("busy_start_ign", {15'd0, bus.busy, 16'(bus.pair_cnt)}, {15'd0, 1'b1, 16'd5});
        pair(1'b0, 8'h00, 1'b1, words[5] ^ 8'h01);
        check("post_ign_pair", 32'(bus.pair_cnt), 32'd6);
        check("post_ign_err", {16'(bus.word_err_cnt), 16'(bus.bit_err_cnt)}, {16'd1, 16'd1});
        check("post_ign_unf", 32'(bus.underflow), 32'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_busy", {30'd0, bus.busy, bus.done}, 32'd0);
        check("midrst_cnts", 32'(bus.pair_cnt) | 32'(bus.word_err_cnt) | 32'(bus.bit_err_cnt), 32'd0);

        // Saturation on the CNT_W=4 instance: every pair fully inverted
        do_reset();
        for (int i = 0; i < 512; i++) mask_a[i] = 8'hFF;
        drive_run("inv", 0, 10, 10, 1);
        check("sat_done_seen", 32'(small_done), 32'd1);
        check("sat_pair", 32'(bus_s.pair_cnt), 32'd10);
        check("sat_word_err", 32'(bus_s.word_err_cnt), 32'd10);
        check("sat_bit_err", 32'(bus_s.bit_err_cnt), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
